// File: rtl/tcp_decode.sv
// tcp_decode: parses a TCP segment byte stream, extracts header fields, skips options,
// forwards payload bytes and verifies the checksum including the IPv4 pseudo-header.
module tcp_decode #(
    parameter logic [15:0] LOCAL_PORT  = 16'd80,
    parameter bit          PORT_FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [7:0]  din,
    input  logic [31:0] sa,
    input  logic [31:0] da,
    input  logic [15:0] seg_len,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [31:0] seq,
    output logic [31:0] ack,
    output logic [7:0]  flags,
    output logic [15:0] window,
    output logic        hdr_done,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_OPT     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DROP    = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] cnt_r;
    logic [15:0] acc_r;
    logic [7:0]  hi_r;
    logic [23:0] sh_r;
    logic [3:0]  doff_r;
    logic [15:0] src_port_r, dst_port_r, window_r;
    logic [31:0] seq_r, ack_r;
    logic [7:0]  flags_r, payload_data_r;
    logic        hdr_done_r, payload_valid_r, done_r, err_r;

    logic [15:0] seed_s, sum_fin_s, hdr_last_s;
    logic        busy_s, hdr_err_s, fin_err_s;
    logic        hdr_done_s, payload_valid_s, done_s, err_s;

    // Ones-complement 16-bit add with end-around carry.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    assign seed_s = csum_add(csum_add(csum_add(csum_add(csum_add(sa[31:16], sa[15:0]),
                    da[31:16]), da[15:0]), 16'h0006), seg_len);
    // An odd-length segment still has its last byte waiting in hi_r as a high byte.
    assign sum_fin_s  = cnt_r[0] ? csum_add(acc_r, {hi_r, 8'h00}) : acc_r;
    assign hdr_last_s = {10'd0, doff_r, 2'b00} - 16'd1;
    assign busy_s     = (state_r == ST_HDR) || (state_r == ST_OPT) ||
                        (state_r == ST_PAYLOAD) || (state_r == ST_DROP);
    assign fin_err_s  = (state_r == ST_DROP) || (cnt_r != seg_len) || (cnt_r < 16'd20) ||
                        (~sum_fin_s != 16'h0000);

    // Header sanity checks on the byte currently presented.
    always_comb begin
        hdr_err_s = 1'b0;
        if (cnt_r == 16'd3) begin
            if ((PORT_FILTER == 1'b1) && ({sh_r[7:0], din} != LOCAL_PORT)) begin
                hdr_err_s = 1'b1;
            end else begin
                hdr_err_s = 1'b0;
            end
        end else if (cnt_r == 16'd12) begin
            if ((din[7:4] < 4'd5) || ({10'd0, din[7:4], 2'b00} > seg_len)) begin
                hdr_err_s = 1'b1;
            end else begin
                hdr_err_s = 1'b0;
            end
        end else begin
            hdr_err_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid) state_s = ST_HDR;
                else       state_s = ST_IDLE;
            end
            ST_HDR: begin
                if (!valid)                state_s = ST_FINISH;
                else if (hdr_err_s)        state_s = ST_DROP;
                else if (cnt_r == 16'd19)  state_s = (doff_r > 4'd5) ? ST_OPT : ST_PAYLOAD;
                else                       state_s = ST_HDR;
            end
            ST_OPT: begin
                if (!valid)                   state_s = ST_FINISH;
                else if (cnt_r == hdr_last_s) state_s = ST_PAYLOAD;
                else                          state_s = ST_OPT;
            end
            ST_PAYLOAD: begin
                if (!valid) state_s = ST_FINISH;
                else        state_s = ST_PAYLOAD;
            end
            ST_DROP: begin
                if (!valid) state_s = ST_FINISH;
                else        state_s = ST_DROP;
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Next values of the strobe/status outputs.
    always_comb begin
        hdr_done_s      = 1'b0;
        payload_valid_s = 1'b0;
        done_s          = 1'b0;
        err_s           = err_r;
        if (valid && (state_r == ST_HDR) && (cnt_r == 16'd19) && !hdr_err_s && (doff_r == 4'd5)) begin
            hdr_done_s = 1'b1;
        end else if (valid && (state_r == ST_OPT) && (cnt_r == hdr_last_s)) begin
            hdr_done_s = 1'b1;
        end else begin
            hdr_done_s = 1'b0;
        end
        if (valid && (state_r == ST_PAYLOAD)) payload_valid_s = 1'b1;
        else                                  payload_valid_s = 1'b0;
        if (busy_s && !valid) done_s = 1'b1;
        else                  done_s = 1'b0;
        if (valid && (state_r == ST_IDLE)) err_s = 1'b0;
        else if (done_s)                   err_s = fin_err_s;
        else                               err_s = err_r;
    end

    // Datapath: byte count, checksum, field capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r           <= 16'd0;
            acc_r           <= 16'd0;
            hi_r            <= 8'd0;
            sh_r            <= 24'd0;
            doff_r          <= 4'd0;
            src_port_r      <= 16'd0;
            dst_port_r      <= 16'd0;
            seq_r           <= 32'd0;
            ack_r           <= 32'd0;
            flags_r         <= 8'd0;
            window_r        <= 16'd0;
            payload_data_r  <= 8'd0;
            hdr_done_r      <= 1'b0;
            payload_valid_r <= 1'b0;
            done_r          <= 1'b0;
            err_r           <= 1'b0;
        end else begin
            hdr_done_r      <= hdr_done_s;
            payload_valid_r <= payload_valid_s;
            done_r          <= done_s;
            err_r           <= err_s;
            if (state_r == ST_FINISH) begin
                cnt_r <= 16'd0;
                acc_r <= 16'd0;
                hi_r  <= 8'd0;
            end else if (valid) begin
                if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'd1;
                if (state_r == ST_IDLE)  acc_r <= seed_s;
                else if (cnt_r[0])       acc_r <= csum_add(acc_r, {hi_r, din});
                if (!cnt_r[0])           hi_r <= din;
                sh_r <= {sh_r[15:0], din};
                if (state_r == ST_PAYLOAD) payload_data_r <= din;
                if ((state_r == ST_HDR) || (state_r == ST_DROP)) begin
                    case (cnt_r)
                        16'd1:   src_port_r <= {sh_r[7:0], din};
                        16'd3:   dst_port_r <= {sh_r[7:0], din};
                        16'd7:   seq_r      <= {sh_r, din};
                        16'd11:  ack_r      <= {sh_r, din};
                        16'd12:  doff_r     <= din[7:4];
                        16'd13:  flags_r    <= din;
                        16'd15:  window_r   <= {sh_r[7:0], din};
                        default: doff_r     <= doff_r;
                    endcase
                end
            end
        end
    end

    assign src_port      = src_port_r;
    assign dst_port      = dst_port_r;
    assign seq           = seq_r;
    assign ack           = ack_r;
    assign flags         = flags_r;
    assign window        = window_r;
    assign hdr_done      = hdr_done_r;
    assign payload_valid = payload_valid_r;
    assign payload_data  = payload_data_r;
    assign done          = done_r;
    assign err           = err_r;

endmodule

// File: tb/tb_tcp_decode.sv
// tb_tcp_decode: directed segments against tcp_decode with filter on and off.
module tb_tcp_decode;

    logic        clk = 1'b0;
    logic        rst_n, valid;
    logic [7:0]  din;
    logic [31:0] sa, da;
    logic [15:0] seg_len;
    logic [15:0] src_port, dst_port, window;
    logic [31:0] seq, ack;
    logic [7:0]  flags, payload_data;
    logic        hdr_done, payload_valid, done, err;
    logic [15:0] src_port_nf, dst_port_nf, window_nf;
    logic [31:0] seq_nf, ack_nf;
    logic [7:0]  flags_nf, payload_data_nf;
    logic        hdr_done_nf, payload_valid_nf, done_nf, err_nf;

    logic [7:0]  seg [0:63];
    int          n_chk = 0, n_pass = 0;
    int          drv_idx, hd_cnt, hd_idx, pv_cnt, done_cnt, nf_done_cnt;
    logic        done_err, nf_err;
    logic [23:0] pv_word;

    always #5 clk = ~clk;

    tcp_decode #(.LOCAL_PORT(16'd80), .PORT_FILTER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .din(din), .sa(sa), .da(da), .seg_len(seg_len),
        .src_port(src_port), .dst_port(dst_port), .seq(seq), .ack(ack), .flags(flags),
        .window(window), .hdr_done(hdr_done), .payload_valid(payload_valid),
        .payload_data(payload_data), .done(done), .err(err));

    tcp_decode #(.LOCAL_PORT(16'd80), .PORT_FILTER(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .valid(valid), .din(din), .sa(sa), .da(da), .seg_len(seg_len),
        .src_port(src_port_nf), .dst_port(dst_port_nf), .seq(seq_nf), .ack(ack_nf),
        .flags(flags_nf), .window(window_nf), .hdr_done(hdr_done_nf),
        .payload_valid(payload_valid_nf), .payload_data(payload_data_nf), .done(done_nf),
        .err(err_nf));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] tb_csum(input int n);
        logic [31:0] s;
        logic [7:0]  lo;
        s = {16'd0, sa[31:16]} + {16'd0, sa[15:0]} + {16'd0, da[31:16]} + {16'd0, da[15:0]} +
            32'h0000_0006 + {16'd0, seg_len};
        for (int i = 0; i < n; i += 2) begin
            lo = (i + 1 < n) ? seg[i + 1] : 8'h00;
            s  = s + {16'd0, seg[i], lo};
        end
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic build(input logic [15:0] dp, input logic [3:0] doff, input int nopt,
                         input int npay, input logic [15:0] slen);
        logic [15:0] c;
        for (int i = 0; i < 64; i++) seg[i] = 8'h00;
        seg[0]  = 8'h12;      seg[1]  = 8'h34;
        seg[2]  = dp[15:8];   seg[3]  = dp[7:0];
        seg[7]  = 8'h01;      seg[12] = {doff, 4'h0};
        seg[13] = 8'h02;      seg[14] = 8'hFF;  seg[15] = 8'hFF;
        for (int i = 0; i < nopt; i++) seg[20 + i] = 8'h01;
        for (int i = 0; i < npay; i++) seg[20 + nopt + i] = 8'h41 + i[7:0];
        seg_len = slen;
        c = tb_csum(20 + nopt + npay);
        seg[16] = c[15:8];
        seg[17] = c[7:0];
    endtask

    // Advance to the next falling edge and record what the DUTs reported.
    task automatic tick();
        @(negedge clk);
        if (hdr_done) begin hd_cnt++; hd_idx = drv_idx; end
        if (payload_valid) begin pv_cnt++; pv_word = {pv_word[15:0], payload_data}; end
        if (done) begin done_cnt++; done_err = err; end
        if (done_nf) begin nf_done_cnt++; nf_err = err_nf; end
    endtask

    task automatic clr_counts();
        hd_cnt = 0; hd_idx = -1; pv_cnt = 0; pv_word = 24'd0;
        done_cnt = 0; done_err = 1'b0; nf_done_cnt = 0; nf_err = 1'b0;
    endtask

    task automatic run_seg(input int nbytes);
        clr_counts();
        for (int i = 0; i < nbytes; i++) begin
            tick();
            valid = 1'b1; din = seg[i]; drv_idx = i;
        end
        tick();
        valid = 1'b0; din = 8'h00; drv_idx = -1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic check_syn_fields(input string tag);
        check({tag, "_fields"}, {src_port, dst_port, seq, ack, flags, window},
              {16'h1234, 16'h0050, 32'h0000_0001, 32'h0000_0000, 8'h02, 16'hFFFF});
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; din = 8'h00; drv_idx = -1;
        sa = 32'hC0A8_0002; da = 32'hC0A8_0001; seg_len = 16'd0;
        clr_counts();
        tick(); tick(); tick();
        check("reset_outputs",
              {src_port, dst_port, seq, ack, flags, window, hdr_done, payload_valid, payload_data, done, err},
              '0);
        rst_n = 1'b1;
        tick();

        // Plain SYN, no payload
        build(16'h0050, 4'd5, 0, 0, 16'd20);
        run_seg(20);
        check("syn_csum_byte", {seg[16], seg[17]}, 16'h1C0A);
        check("syn_hd_cnt", hd_cnt, 1);
        check("syn_hd_idx", hd_idx, 19);
        check("syn_done", done_cnt, 1);
        check("syn_err", done_err, 1'b0);
        check("syn_pv_cnt", pv_cnt, 0);
        check_syn_fields("syn");

        // SYN with odd-length payload "ABC"
        build(16'h0050, 4'd5, 0, 3, 16'd23);
        run_seg(23);
        check("abc_hd_idx", hd_idx, 19);
        check("abc_pv_cnt", pv_cnt, 3);
        check("abc_pv_data", pv_word, 24'h414243);
        check("abc_done", done_cnt, 1);
        check("abc_err", done_err, 1'b0);

        // Corrupted checksum byte
        build(16'h0050, 4'd5, 0, 3, 16'd23);
        seg[16] = seg[16] ^ 8'h01;
        run_seg(23);
        check("badck_err", done_err, 1'b1);
        check("badck_pv_cnt", pv_cnt, 3);
        check("badck_err_hold", err, 1'b1);

        // Wrong destination port
        build(16'h0051, 4'd5, 0, 3, 16'd23);
        run_seg(23);
        check("port_hd_cnt", hd_cnt, 0);
        check("port_pv_cnt", pv_cnt, 0);
        check("port_done", done_cnt, 1);
        check("port_err", done_err, 1'b1);
        check("port_nf_done", nf_done_cnt, 1);
        check("port_nf_err", nf_err, 1'b0);

        // Options present: doff 6, 4 option bytes, 2 payload bytes
        build(16'h0050, 4'd6, 4, 2, 16'd26);
        run_seg(26);
        check("opt_hd_cnt", hd_cnt, 1);
        check("opt_hd_idx", hd_idx, 23);
        check("opt_pv_cnt", pv_cnt, 2);
        check("opt_pv_data", pv_word[15:0], 16'h4142);
        check("opt_err", done_err, 1'b0);
        check("opt_err_hold", err, 1'b0);

        // Data offset below minimum
        build(16'h0050, 4'd4, 0, 0, 16'd20);
        run_seg(20);
        check("doff4_hd_cnt", hd_cnt, 0);
        check("doff4_err", done_err, 1'b1);

        // Truncated header: valid drops after idx 9
        build(16'h0050, 4'd5, 0, 0, 16'd20);
        run_seg(10);
        check("trunc_done", done_cnt, 1);
        check("trunc_err", done_err, 1'b1);
        check("trunc_hd_cnt", hd_cnt, 0);

        // Reset asserted together with byte idx 5
        build(16'h0050, 4'd5, 0, 0, 16'd20);
        clr_counts();
        for (int i = 0; i < 6; i++) begin
            tick();
            valid = 1'b1; din = seg[i]; drv_idx = i;
            if (i == 5) rst_n = 1'b0;
        end
        tick();
        rst_n = 1'b1; valid = 1'b0; din = 8'h00; drv_idx = -1;
        check("midrst_outputs",
              {src_port, dst_port, seq, ack, flags, window, hdr_done, payload_valid, payload_data, done, err},
              '0);
        for (int i = 0; i < 4; i++) tick();
        check("midrst_no_done", done_cnt, 0);

        // Clean segment after the aborted one
        run_seg(20);
        check("post_hd_idx", hd_idx, 19);
        check("post_done", done_cnt, 1);
        check("post_err", done_err, 1'b0);
        check_syn_fields("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
